cam_search_ctrl: RTL

//  Sequential front-end for the CAM cell array: accepts one read/write/search/invalidate

---
 rtl/cam_search_ctrl.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/cam_search_ctrl.sv
// CAM front-end: one read/write/search/invalidate per handshake, registered
// one-hot array strobes, per-entry valid vector and lowest-index hit encoder.
// Optional macro CAM_MULTIHIT_EN enables the rsp_multihit_o flag.
// Ports: clk_i, rst_n_i (async, active low); req_* request channel;
// write/read/compare_enable_o and cell_data_o drive the array; match_i and
// read_data_i come back from it; rsp_* response channel.
module cam_search_ctrl #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 1 << ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [1:0]            req_op_i,
  input  logic [ADDR_WIDTH-1:0] req_index_i,
  input  logic [WIDTH-1:0]      req_data_i,
  output logic [DEPTH-1:0]      write_enable_o,
  output logic [DEPTH-1:0]      read_enable_o,
  output logic [DEPTH-1:0]      compare_enable_o,
  output logic [WIDTH-1:0]      cell_data_o,
  input  logic [DEPTH-1:0]      match_i,
  input  logic [WIDTH-1:0]      read_data_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic                  rsp_hit_o,
  output logic [ADDR_WIDTH-1:0] rsp_index_o,
  output logic [WIDTH-1:0]      rsp_data_o,
  output logic                  rsp_multihit_o
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_e;

  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_SR  = 2'b10;
  localparam logic [1:0] OP_INV = 2'b11;

  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  state_e                state_q, state_d;
  logic [1:0]            op_q, op_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic                  in_rng_q, in_rng_d;
  logic [WIDTH-1:0]      data_q, data_d;
  logic [DEPTH-1:0]      we_q, we_d;
  logic [DEPTH-1:0]      re_q, re_d;
  logic [DEPTH-1:0]      ce_q, ce_d;
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_hit_q, rsp_hit_d;
  logic [ADDR_WIDTH-1:0] rsp_index_q, rsp_index_d;
  logic [WIDTH-1:0]      rsp_data_q, rsp_data_d;
  logic                  rsp_mh_q, rsp_mh_d;

  logic                  req_in_rng;
  logic [DEPTH-1:0]      req_oh;
  logic [DEPTH-1:0]      idx_oh;
  logic [DEPTH-1:0]      hits;
  logic [ADDR_WIDTH-1:0] hit_idx;
  logic                  multi;

  // Out-of-range indices yield an all-zero mask, so no strobe and
  // no valid-bit change can ever reach a nonexistent entry.
  assign req_in_rng = 32'(req_index_i) < DEPTH_U;
  assign req_oh     = req_in_rng ? (DEPTH'(1) << req_index_i) : '0;
  assign idx_oh     = in_rng_q ? (DEPTH'(1) << idx_q) : '0;

  // Stale match lines on invalid entries must not count as hits.
  assign hits = match_i & valid_q;

  always_comb begin
    hit_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (hits[i]) hit_idx = ADDR_WIDTH'(i);
    end
  end

`ifdef CAM_MULTIHIT_EN
  // Clearing the lowest set bit leaves something iff two or more were set.
  assign multi = |(hits & (hits - DEPTH'(1)));
`else
  assign multi = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    idx_d       = idx_q;
    in_rng_d    = in_rng_q;
    data_d      = data_q;
    we_d        = '0;
    re_d        = '0;
    ce_d        = '0;
    valid_d     = valid_q;
    rsp_valid_d = rsp_valid_q;
    rsp_hit_d   = rsp_hit_q;
    rsp_index_d = rsp_index_q;
    rsp_data_d  = rsp_data_q;
    rsp_mh_d    = rsp_mh_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          state_d  = ISSUE;
          op_d     = req_op_i;
          idx_d    = req_index_i;
          in_rng_d = req_in_rng;
          data_d   = req_data_i;
          unique case (req_op_i)
            OP_RD:   re_d = req_oh;
            OP_WR:   we_d = req_oh;
            OP_SR:   ce_d = valid_q;
            default: ;
          endcase
        end
      end
      ISSUE: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_hit_d   = 1'b0;
        rsp_index_d = idx_q;
        rsp_data_d  = '0;
        rsp_mh_d    = 1'b0;
        unique case (op_q)
          OP_RD: begin
            rsp_hit_d  = |(valid_q & idx_oh);
            rsp_data_d = in_rng_q ? read_data_i : '0;
          end
          OP_WR: valid_d = valid_q | idx_oh;
          OP_SR: begin
            rsp_hit_d   = |hits;
            rsp_index_d = hit_idx;
            rsp_mh_d    = multi;
          end
          OP_INV: valid_d = valid_q & ~idx_oh;
          default: ;
        endcase
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      op_q        <= OP_RD;
      idx_q       <= '0;
      in_rng_q    <= 1'b0;
      data_q      <= '0;
      we_q        <= '0;
      re_q        <= '0;
      ce_q        <= '0;
      valid_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_index_q <= '0;
      rsp_data_q  <= '0;
      rsp_mh_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      idx_q       <= idx_d;
      in_rng_q    <= in_rng_d;
      data_q      <= data_d;
      we_q        <= we_d;
      re_q        <= re_d;
      ce_q        <= ce_d;
      valid_q     <= valid_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_index_q <= rsp_index_d;
      rsp_data_q  <= rsp_data_d;
      rsp_mh_q    <= rsp_mh_d;
    end
  end

  assign req_ready_o      = (state_q == IDLE);
  assign write_enable_o   = we_q;
  assign read_enable_o    = re_q;
  assign compare_enable_o = ce_q;
  assign cell_data_o      = data_q;
  assign rsp_valid_o      = rsp_valid_q;
  assign rsp_hit_o        = rsp_hit_q;
  assign rsp_index_o      = rsp_index_q;
  assign rsp_data_o       = rsp_data_q;
  assign rsp_multihit_o   = rsp_mh_q;

endmodule
